// File: rtl/uart_dpram_pkg.sv
// Shared types and defaults for the UART-to-dual-port-RAM buffer controller.
package uart_dpram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        TXW  = 3'd4
    } state_t;

endpackage

// File: rtl/dpram_ptr_ctrl.sv
// Circular-buffer bookkeeping: write/read pointers, fill count and the full check.
// Pointers wrap naturally at DEPTH because they are exactly ADDR_W bits wide.
module dpram_ptr_ctrl
    import uart_dpram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic              pop,
    output logic              push_ok,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   count,
    output logic              drop
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic full;

    // Full is judged on the count at the start of the cycle, so a same-cycle pop never frees room.
    assign full    = (count == DEPTH);
    assign push_ok = push_req && !full;
    assign drop    = push_req && full;

    // Pointer and count update; simultaneous push and pop leave the count untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_dpram_ctrl.sv
// UART receive bytes are stored in a dual-port RAM FIFO; a key press replays
// everything stored at that moment to the UART transmitter, one byte per tx_done.
// Optional feature: define DPRAM_CTRL_OVF_EN for a sticky dropped-byte flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a key press with data stored
// RD    | read address holds rd_ptr, RAM access in flight
// WAIT  | extra cycle for a two-cycle RAM read
// SEND  | capture read data, pulse send_en, pop one byte
// TXW   | wait for transmitter to finish the byte
module uart_dpram_ctrl
    import uart_dpram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              key_flag,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              send_en,
    input  logic              tx_done,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    state_t            state;
    logic [ADDR_W:0]   remain;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop;
    logic              start;
`ifdef DPRAM_CTRL_OVF_EN
    logic              drop;
`endif

    assign pop   = (state == SEND);
    assign start = (state == IDLE) && key_flag && (count != '0);

    dpram_ptr_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .push_req (rx_done),
        .pop      (pop),
        .push_ok  (push_ok),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count),
`ifdef DPRAM_CTRL_OVF_EN
        .drop     (drop)
`else
        .drop     ()
`endif
    );

    // Write port: one registered strobe per accepted byte at the pre-increment pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= push_ok;
            if (push_ok) begin
                wr_addr <= wr_ptr;
                wr_data <= rx_data;
            end
        end
    end

    // Readout FSM. rd_addr is loaded one step ahead so the RAM data is ready
    // by SEND, giving the first send_en RD_LAT+2 cycles after the key press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            remain  <= '0;
            rd_addr <= '0;
            tx_data <= '0;
            send_en <= 1'b0;
            busy    <= 1'b0;
        end else begin
            send_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remain  <= count;
                        rd_addr <= rd_ptr;
                        busy    <= 1'b1;
                        state   <= RD;
                    end
                end
                RD: begin
                    rd_addr <= rd_ptr;
                    state   <= (RD_LAT == 2) ? WAIT : SEND;
                end
                WAIT: begin
                    state <= SEND;
                end
                SEND: begin
                    tx_data <= rd_data;
                    send_en <= 1'b1;
                    remain  <= remain - (ADDR_W+1)'(1);
                    rd_addr <= rd_ptr + ADDR_W'(1);
                    state   <= TXW;
                end
                TXW: begin
                    if (tx_done) begin
                        if (remain != '0) begin
                            state <= RD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DPRAM_CTRL_OVF_EN
    // Sticky drop flag; a drop in the same cycle as a burst start still sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (start)
            overflow <= 1'b0;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/uart_dpram_ctrl.md
UART_DPRAM_CTRL -- requirements
Module: uart_dpram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: dpram address width; DEPTH = 2**ADDR_W.
REQ-002 SHALL have parameter RD_LAT, default 1: dpram read latency in clk cycles, legal values 1..2.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rx_data  in  8  received UART byte, valid while rx_done=1.
REQ-006 rx_done  in  1  one-cycle pulse per received byte.
REQ-007 key_flag  in  1  one-cycle debounced key-press pulse.
REQ-008 wr_en  out  1  dpram write strobe, one cycle per byte.
REQ-009 wr_addr  out  ADDR_W  dpram write address.
REQ-010 wr_data  out  8  dpram write data.
REQ-011 rd_addr  out  ADDR_W  dpram read address.
REQ-012 rd_data  in  8  dpram read data, valid RD_LAT cycles after rd_addr.
REQ-013 tx_data  out  8  byte to UART transmitter.
REQ-014 send_en  out  1  one-cycle transmit start pulse.
REQ-015 tx_done  in  1  one-cycle transmit-complete pulse.
REQ-016 busy  out  1  high whenever FSM is not IDLE.
REQ-017 count  out  ADDR_W+1  bytes stored, 0..DEPTH.
REQ-018 overflow  out  1  sticky dropped-byte flag.

Function
REQ-019 Buffer SHALL be a circular FIFO over the dpram: wr_ptr, rd_ptr (ADDR_W bits, wrap DEPTH-1 -> 0) and count.
REQ-020 rx_done with count<DEPTH SHALL, next cycle, give wr_en=1, wr_addr=wr_ptr, wr_data=rx_data; wr_ptr+1, count+1.
REQ-021 rx_done with count==DEPTH SHALL drop the byte: no wr_en, pointers and count unchanged.
REQ-022 FSM states SHALL be IDLE, RD, WAIT, SEND, TXW.
REQ-023 IDLE: key_flag with count!=0 -> RD, latching remain=count; with count==0 -> stay IDLE.
REQ-024 RD: rd_addr=rd_ptr; -> WAIT if RD_LAT==2, else -> SEND.
REQ-025 WAIT: one cycle, -> SEND.
REQ-026 SEND: tx_data<=rd_data, send_en=1 for one cycle, rd_ptr+1, count-1, remain-1; -> TXW.
REQ-027 TXW: hold until tx_done; then -> RD if remain!=0, else -> IDLE.
REQ-028 First send_en SHALL occur RD_LAT+2 cycles after the key_flag cycle.
REQ-029 Same-cycle accepted write and SEND pop SHALL leave count unchanged; the full check uses pre-cycle count.
REQ-030 Bytes written during readout SHALL NOT join the current burst (remain is fixed) but remain stored for the next press.
REQ-031 key_flag while busy=1 and tx_done outside TXW SHALL be ignored.

Reset
REQ-032 rst=1 SHALL immediately force FSM=IDLE; wr_ptr=rd_ptr=remain=count=0; wr_en=send_en=busy=overflow=0; wr_addr=wr_data=rd_addr=tx_data=0.
REQ-033 rst mid-burst SHALL abort with no further send_en; stored bytes are discarded.

Configuration
REQ-034 Macro DPRAM_CTRL_OVF_EN defined: a dropped byte (REQ-021) sets overflow=1, cleared only by rst or on entry to RD.
REQ-035 Macro DPRAM_CTRL_OVF_EN undefined: overflow tied 0, no overflow register; all other behaviour identical.

Structure
REQ-036 Package uart_dpram_pkg SHALL hold the FSM state enum typedef and defaults for ADDR_W and RD_LAT.
REQ-037 Sub-module dpram_ptr_ctrl SHALL own wr_ptr/rd_ptr/count update and the full check; the FSM and output registers stay in the top.

Verification
REQ-038 Receive 0xAA, press key -> wr_en once at addr 0; one send_en with tx_data=0xAA; count 1->0; busy falls after tx_done.
REQ-039 Receive 0xAA, 0xF0, 0x55, press key -> three send_en in order AA, F0, 55, each only after the prior tx_done; count ends 0.
REQ-040 ADDR_W=2: receive 5 bytes 01..05 -> count=4, 05 dropped, overflow=1 (with macro) or 0 (without); after readout, receive 06 -> written at wr_addr 0 (wrap).
REQ-041 Press key with count=0 -> no send_en, busy stays 0; second key_flag during a burst -> ignored, burst length unchanged.
REQ-042 Receive 0x11, press key, receive 0x22 during TXW -> burst sends only 11; count=1; next press sends 22.
REQ-043 Assert rst during TXW of a 3-byte burst -> send_en never reasserts, count=0, busy=0, outputs at reset values.
